fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the five-stage WISC pipeline. Owns the PC register and fetches one instruction per handshake from a multi-cycle instruction memory. Holds the fetched word stable until the stall signal from the hazard detector (`pcNop`) releases it. Presents the word to the hazard detector as `fetch_inst`, substituting NOP while no valid instruction is held, and accepts taken-branch/jump redirects from execute.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall_i` input 1: hazard detector `pcNop`. 1 = hold the current instruction and PC.
- `redirect_i` input 1: taken branch/jump resolved this cycle.
- `redirect_pc_i` input 16: redirect target.
- `imem_req_o` output 1: read request. Held high until ack.
- `imem_addr_o` output 16: read address; equals PC while `imem_req_o`=1.
- `imem_ack_i` input 1: read data valid this cycle. Exactly one ack per request episode; never in the same cycle `imem_req_o` first rises.
- `imem_data_i` input 16: read data, sampled when `imem_ack_i`=1.
- `fetch_inst_o` output 16: held instruction, or 16'h0800 (NOP) when `fetch_valid_o`=0.
- `fetch_valid_o` output 1: `fetch_inst_o` holds a real fetched instruction.
- `fetch_pc_o` output 16: PC of the held instruction.
- `fetch_pc_inc_o` output 16: `fetch_pc_o` + 2, modulo 2^16.
- `halt_o` output 1: HALT consumed; fetch stopped.
- `err_o` output 1: misaligned redirect. Only present with `FETCH_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- **States:** BOOT, REQ, HOLD, DROP, HALTED.
- **Event priority:** redirect > ack > stall.
- **BOOT:** entered on reset. `imem_req_o`=0. Goes to REQ on the next edge.
- **REQ:** `imem_req_o`=1, `imem_addr_o`=PC.
  - On ack: IR <= `imem_data_i`, go to HOLD.
  - On redirect with ack in the same cycle: data discarded, PC <= target, stay in REQ (new request next cycle).
  - On redirect without ack: PC <= target, go to DROP.
- **HOLD:** `fetch_valid_o`=1.
  - `stall_i`=1: no change.
  - `stall_i`=0 and IR[15:11]≠5'b00000: PC <= PC+2, go to REQ.
  - `stall_i`=0 and IR[15:11]=5'b00000 (HALT): PC unchanged, go to HALTED.
  - Redirect: PC <= target, go to REQ. The held instruction is dropped regardless of `stall_i`.
- **DROP:** `imem_req_o`=0. Waits for the outstanding ack, discards its data, then goes to REQ. A second redirect while in DROP only updates PC.
- **HALTED:** `halt_o`=1, `imem_req_o`=0, `fetch_valid_o`=0. A redirect leaves HALTED for REQ with PC <= target (this covers a wrong-path HALT). Otherwise HALTED persists until reset.
- **Arithmetic:** PC+2 wraps from 16'hFFFE to 16'h0000. No trap on wrap.

## Timing
- **Reset values:** PC=`RESET_PC`, IR=16'h0800, state=BOOT. All outputs 0 except `fetch_inst_o`=16'h0800 and `fetch_pc_inc_o`=`RESET_PC`+2.
- **Reset mid-operation:** everything returns to reset values immediately. An ack arriving while in BOOT is ignored. Memory is assumed reset together with this block.
- **Fetch latency:** ack arriving N≥1 cycles after the request rises gives `fetch_valid_o`=1 on the cycle after the ack.
- **Throughput:** one instruction per 3 cycles at best (1-cycle memory, no stall).
- **Handshake rules:**
  - `imem_addr_o` is stable for the whole request episode.
  - A redirect never changes the address of a live request.
  - An instruction is consumed at an edge where state=HOLD and `stall_i`=0 and `redirect_i`=0.
- **Output timing:** all outputs are combinational from registered state; no input→output combinational path.

## Configuration
- **`FETCH_ALIGN_CHECK_EN`** defined: a redirect with `redirect_pc_i[0]`=1 sets `err_o`=1 (sticky until reset) and enters HALTED instead of fetching.
- **`FETCH_ALIGN_CHECK_EN`** undefined: bit 0 of the target is forced to 0 and `err_o` is constant 0.

## Structure
- **Shared package:** NOP encoding 16'h0800, HALT opcode 5'b00000, state enumeration, `RESET_PC` default.
- **Sub-module `fetch_pc_sel`:** combinational next-PC mux (hold / +2 / redirect, plus alignment handling under the macro). The FSM, PC register and IR stay in `fetch_unit`.

## Test plan
- **Reset and first fetch:** reset release, memory acks 1 cycle after req with 16'h4123 → addr 0x0000 requested; `fetch_valid_o`=1, `fetch_inst_o`=16'h4123, `fetch_pc_inc_o`=0x0002 two cycles after req.
- **Stall hold:** HOLD with `stall_i`=1 for 4 cycles → `fetch_inst_o` and `fetch_pc_o` frozen, `imem_req_o`=0. Releasing the stall gives a request at PC+2 next cycle.
- **Redirect during live request:** redirect to 0x0100 two cycles before ack (3-cycle memory) → DROP; stale data never appears on `fetch_inst_o`; next request addr=0x0100.
- **Simultaneous ack and redirect:** ack and redirect to 0x0040 in the same cycle → `fetch_valid_o` stays 0; request at 0x0040 next cycle.
- **HALT:** fetch 16'h0000, consume it → `halt_o`=1, no further requests for 10 cycles. Then redirect to 0x0020 → request at 0x0020, `halt_o`=0.
- **Misaligned redirect:** redirect to 0x0033 → with macro, `err_o`=1 and `halt_o`=1; without macro, request addr=0x0032.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the WISC instruction fetch stage: encodings, FSM states, PC select codes.
package fetch_unit_pkg;

  localparam logic [15:0] NOP_INST         = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE      = 5'b00000;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_REQ    = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DROP   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC mux for fetch_unit. With FETCH_ALIGN_CHECK_EN the redirect target is
// passed through and flagged when odd; otherwise bit 0 of the target is cleared.
module fetch_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [15:0] i_pc,
  input  logic [1:0]  i_sel,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_next_pc,
  output logic [15:0] o_pc_inc,
  output logic        o_misaligned
);

  logic [15:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_target     = i_redirect_pc;
  assign o_misaligned = i_redirect_pc[0];
`else
  assign w_target     = i_redirect_pc & 16'hFFFE;
  assign o_misaligned = 1'b0;
`endif

  assign o_pc_inc = i_pc + 16'd2;

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      PC_INC:   o_next_pc = o_pc_inc;
      PC_REDIR: o_next_pc = w_target;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch stage: PC/IR registers and request FSM over a multi-cycle instruction memory.
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets raise a sticky err_o and halt fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] fetch_inst_o,
  output logic        fetch_valid_o,
  output logic [15:0] fetch_pc_o,
  output logic [15:0] fetch_pc_inc_o,
  output logic        halt_o,
  output logic        err_o
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_ir;
  logic [15:0]  w_next_pc;
  logic [15:0]  w_pc_inc;
  logic [1:0]   w_pc_sel;
  logic         w_ir_load;
  logic         w_misaligned;
  logic         w_bad_redirect;

  fetch_pc_sel u_pc_sel (
    .i_pc          (r_pc),
    .i_sel         (w_pc_sel),
    .i_redirect_pc (redirect_pc_i),
    .o_next_pc     (w_next_pc),
    .o_pc_inc      (w_pc_inc),
    .o_misaligned  (w_misaligned)
  );

  assign w_bad_redirect = redirect_i && w_misaligned && (r_state != ST_BOOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INST;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_ir_load) r_ir <= imem_data_i;
    end
  end

  // A misaligned redirect leaves the PC alone and parks in HALTED.
  always_comb begin
    w_next_state = r_state;
    w_pc_sel     = PC_HOLD;
    w_ir_load    = 1'b0;
    case (r_state)
      ST_BOOT: w_next_state = ST_REQ;
      ST_REQ: begin
        if (w_bad_redirect) begin
          w_next_state = ST_HALTED;
        end else if (redirect_i) begin
          w_pc_sel     = PC_REDIR;
          w_next_state = imem_ack_i ? ST_REQ : ST_DROP;
        end else if (imem_ack_i) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_bad_redirect) begin
          w_next_state = ST_HALTED;
        end else if (redirect_i) begin
          w_pc_sel     = PC_REDIR;
          w_next_state = ST_REQ;
        end else if (!stall_i) begin
          if (r_ir[15:11] == HALT_OPCODE) begin
            w_next_state = ST_HALTED;
          end else begin
            w_pc_sel     = PC_INC;
            w_next_state = ST_REQ;
          end
        end
      end
      ST_DROP: begin
        if (w_bad_redirect) begin
          w_next_state = ST_HALTED;
        end else begin
          if (redirect_i) w_pc_sel = PC_REDIR;
          if (imem_ack_i) w_next_state = ST_REQ;
        end
      end
      ST_HALTED: begin
        if (redirect_i && !w_bad_redirect) begin
          w_pc_sel     = PC_REDIR;
          w_next_state = ST_REQ;
        end
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_bad_redirect) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign imem_req_o     = (r_state == ST_REQ);
  assign imem_addr_o    = imem_req_o ? r_pc : 16'h0000;
  assign fetch_valid_o  = (r_state == ST_HOLD);
  assign fetch_inst_o   = fetch_valid_o ? r_ir : NOP_INST;
  assign fetch_pc_o     = r_pc;
  assign fetch_pc_inc_o = w_pc_inc;
  assign halt_o         = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_data_i;
  logic [15:0] fetch_inst_o;
  logic        fetch_valid_o;
  logic [15:0] fetch_pc_o;
  logic [15:0] fetch_pc_inc_o;
  logic        halt_o;
  logic        err_o;

  int checks;
  int failures;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_data_i    (imem_data_i),
    .fetch_inst_o   (fetch_inst_o),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_pc_o     (fetch_pc_o),
    .fetch_pc_inc_o (fetch_pc_inc_o),
    .halt_o         (halt_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fetch_valid_o); end
    checks++; if (fetch_inst_o !== 16'h0800) begin failures++; $display("FAIL reset_inst got=%h exp=0800", fetch_inst_o); end
    checks++; if (fetch_pc_o !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", fetch_pc_o); end
    checks++; if (fetch_pc_inc_o !== 16'h0002) begin failures++; $display("FAIL reset_pc_inc got=%h exp=0002", fetch_pc_inc_o); end
    checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0000) begin failures++; $display("FAIL first_addr got=%h exp=0000", imem_addr_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL first_valid_early got=%b exp=0", fetch_valid_o); end
    imem_ack_i = 1'b1; imem_data_i = 16'h4123; stall_i = 1'b1;
    step();
    imem_ack_i = 1'b0; imem_data_i = 16'h0000;
    checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", fetch_valid_o); end
    checks++; if (fetch_inst_o !== 16'h4123) begin failures++; $display("FAIL first_inst got=%h exp=4123", fetch_inst_o); end
    checks++; if (fetch_pc_inc_o !== 16'h0002) begin failures++; $display("FAIL first_pc_inc got=%h exp=0002", fetch_pc_inc_o); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (fetch_inst_o !== 16'h4123) begin failures++; $display("FAIL stall_inst cyc=%0d got=%h exp=4123", i, fetch_inst_o); end
      checks++; if (fetch_pc_o !== 16'h0000) begin failures++; $display("FAIL stall_pc cyc=%0d got=%h exp=0000", i, fetch_pc_o); end
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req cyc=%0d got=%b exp=0", i, imem_req_o); end
    end
    stall_i = 1'b0;
    step();
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL release_req got=%b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0002) begin failures++; $display("FAIL release_addr got=%h exp=0002", imem_addr_o); end
  endtask

  task automatic test_redirect_live();
    redirect_i = 1'b1; redirect_pc_i = 16'h0100;
    step();
    redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL drop_req got=%b exp=0", imem_req_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL drop_valid got=%b exp=0", fetch_valid_o); end
    step();
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL drop_wait_req got=%b exp=0", imem_req_o); end
    imem_ack_i = 1'b1; imem_data_i = 16'hBEEF;
    step();
    imem_ack_i = 1'b0; imem_data_i = 16'h0000;
    checks++; if (fetch_inst_o !== 16'h0800) begin failures++; $display("FAIL drop_stale_inst got=%h exp=0800", fetch_inst_o); end
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL drop_new_req got=%b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0100) begin failures++; $display("FAIL drop_new_addr got=%h exp=0100", imem_addr_o); end
  endtask

  task automatic test_ack_redirect();
    imem_ack_i = 1'b1; imem_data_i = 16'h5555;
    redirect_i = 1'b1; redirect_pc_i = 16'h0040;
    step();
    imem_ack_i = 1'b0; redirect_i = 1'b0;
    checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL ackredir_valid got=%b exp=0", fetch_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL ackredir_req got=%b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0040) begin failures++; $display("FAIL ackredir_addr got=%h exp=0040", imem_addr_o); end
  endtask

  task automatic test_halt();
    imem_ack_i = 1'b1; imem_data_i = 16'h0000; stall_i = 1'b1;
    step();
    imem_ack_i = 1'b0; imem_data_i = 16'hFFFF;
    checks++; if (fetch_inst_o !== 16'h0000) begin failures++; $display("FAIL halt_inst got=%h exp=0000", fetch_inst_o); end
    checks++; if (fetch_pc_o !== 16'h0040) begin failures++; $display("FAIL halt_pc got=%h exp=0040", fetch_pc_o); end
    stall_i = 1'b0;
    step();
    checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halt_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", fetch_valid_o); end
    checks++; if (fetch_pc_o !== 16'h0040) begin failures++; $display("FAIL halt_pc_kept got=%h exp=0040", fetch_pc_o); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (imem_req_o !== 1'b0 || halt_o !== 1'b1) begin failures++; $display("FAIL halt_idle cyc=%0d req=%b halt=%b exp req=0 halt=1", i, imem_req_o, halt_o); end
    end
    redirect_i = 1'b1; redirect_pc_i = 16'h0020;
    step();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 16'h0020 || imem_req_o !== 1'b1) begin failures++; $display("FAIL unhalt_req addr=%h req=%b exp addr=0020 req=1", imem_addr_o, imem_req_o); end
    checks++; if (halt_o !== 1'b0) begin failures++; $display("FAIL unhalt_flag got=%b exp=0", halt_o); end
  endtask

  task automatic test_misaligned();
    imem_ack_i = 1'b1; imem_data_i = 16'h6000;
    step();
    imem_ack_i = 1'b0;
    checks++; if (fetch_inst_o !== 16'h6000) begin failures++; $display("FAIL mis_pre_inst got=%h exp=6000", fetch_inst_o); end
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h0033;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", err_o); end
    checks++; if (halt_o !== 1'b1) begin failures++; $display("FAIL mis_halt got=%b exp=1", halt_o); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", imem_req_o); end
`else
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL mis_req got=%b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 16'h0032) begin failures++; $display("FAIL mis_addr got=%h exp=0032", imem_addr_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", err_o); end
`endif
  endtask

  task automatic test_wrap();
`ifndef FETCH_ALIGN_CHECK_EN
    imem_ack_i = 1'b1; imem_data_i = 16'h4000;
    step();
    imem_ack_i = 1'b0;
`endif
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFE;
    step();
    redirect_i = 1'b0;
    checks++; if (imem_addr_o !== 16'hFFFE || halt_o !== 1'b0) begin failures++; $display("FAIL wrap_req addr=%h halt=%b exp addr=fffe halt=0", imem_addr_o, halt_o); end
    imem_ack_i = 1'b1; imem_data_i = 16'h4111;
    step();
    imem_ack_i = 1'b0;
    checks++; if (fetch_pc_o !== 16'hFFFE) begin failures++; $display("FAIL wrap_pc got=%h exp=fffe", fetch_pc_o); end
    checks++; if (fetch_pc_inc_o !== 16'h0000) begin failures++; $display("FAIL wrap_pc_inc got=%h exp=0000", fetch_pc_inc_o); end
    checks++; if (fetch_inst_o !== 16'h4111) begin failures++; $display("FAIL wrap_inst got=%h exp=4111", fetch_inst_o); end
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin failures++; $display("FAIL wrap_next req=%b addr=%h exp req=1 addr=0000", imem_req_o, imem_addr_o); end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_o); end
`endif
  endtask

  task automatic test_reset_mid();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || fetch_valid_o !== 1'b0 || halt_o !== 1'b0) begin failures++; $display("FAIL midrst_ctrl req=%b valid=%b halt=%b exp all 0", imem_req_o, fetch_valid_o, halt_o); end
    checks++; if (fetch_pc_o !== 16'h0000 || err_o !== 1'b0) begin failures++; $display("FAIL midrst_pc pc=%h err=%b exp pc=0000 err=0", fetch_pc_o, err_o); end
    @(negedge clk);
    rst_n = 1'b1; imem_ack_i = 1'b1; imem_data_i = 16'h1234;
    step();
    imem_ack_i = 1'b0;
    checks++; if (fetch_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin failures++; $display("FAIL boot_ack valid=%b req=%b exp valid=0 req=1", fetch_valid_o, imem_req_o); end
    step();
    imem_ack_i = 1'b1; imem_data_i = 16'h7777;
    step();
    imem_ack_i = 1'b0;
    checks++; if (fetch_inst_o !== 16'h7777 || fetch_pc_o !== 16'h0000) begin failures++; $display("FAIL postrst_fetch inst=%h pc=%h exp inst=7777 pc=0000", fetch_inst_o, fetch_pc_o); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    imem_ack_i = 1'b0; imem_data_i = 16'h0000;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_live();
    test_ack_redirect();
    test_halt();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
